// File: rtl/btn_pkg.sv
// Shared constants and encodings for the push-button conditioner:
// button bit positions, direction command encoding and direction FSM states.
package btn_pkg;

    localparam int NUM_BTNS = 5;

    localparam int BTN_C = 0;
    localparam int BTN_U = 1;
    localparam int BTN_R = 2;
    localparam int BTN_L = 3;
    localparam int BTN_D = 4;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_DOWN  = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STOPPED = 2'd1,
        ST_MOVING  = 2'd2
    } state_t;

    // Highest-priority direction among simultaneous presses (U > R > L > D).
    function automatic dir_t pickDir(input logic [NUM_BTNS-1:0] press);
        dir_t d;
        d = DIR_NONE;
        if (press[BTN_U])      d = DIR_UP;
        else if (press[BTN_R]) d = DIR_RIGHT;
        else if (press[BTN_L]) d = DIR_LEFT;
        else if (press[BTN_D]) d = DIR_DOWN;
        return d;
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Bundle of raw buttons, the stop request and all conditioned outputs
// exchanged between the button conditioner and its surroundings.
interface btn_conditioner_if;
    import btn_pkg::*;

    logic       btnC;
    logic       btnU;
    logic       btnR;
    logic       btnL;
    logic       btnD;
    logic       stop;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [4:0] btn_release;
    logic       armed;
    logic       centre_req;
    dir_t       dir_cmd;

    modport master (
        output btnC, btnU, btnR, btnL, btnD, stop,
        input  btn_level, btn_press, btn_release, armed, centre_req, dir_cmd
    );

    modport slave (
        input  btnC, btnU, btnR, btnL, btnD, stop,
        output btn_level, btn_press, btn_release, armed, centre_req, dir_cmd
    );
endinterface

// File: rtl/btn_debounce.sv
// One button: multi-flop synchroniser, stability counter and
// one-cycle rise/fall pulses coincident with the accepted level change.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btnRaw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] syncReg;
    logic [CW-1:0]          countReg;
    logic                   levelReg;
    logic                   riseReg;
    logic                   fallReg;
    logic                   sample;

    assign sample = syncReg[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            syncReg  <= '0;
            countReg <= '0;
            levelReg <= 1'b0;
            riseReg  <= 1'b0;
            fallReg  <= 1'b0;
        end else begin
            syncReg <= {syncReg[SYNC_STAGES-2:0], btnRaw};
            riseReg <= 1'b0;
            fallReg <= 1'b0;
            if (sample == levelReg) begin
                countReg <= '0;
            end else if (countReg == LAST_COUNT) begin
                // This sample completes the stable run: accept it now.
                countReg <= '0;
                levelReg <= sample;
                riseReg  <= sample;
                fallReg  <= ~sample;
            end else begin
                countReg <= countReg + CW'(1);
            end
        end
    end

    assign level = levelReg;
    assign rise  = riseReg;
    assign fall  = fallReg;

endmodule

// File: rtl/btn_conditioner.sv
// Debounces the five board buttons and turns presses into a latched
// movement direction plus centre requests for the player-movement logic.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    btn_conditioner_if.slave bus
);

    logic [NUM_BTNS-1:0] rawBtns;
    logic [NUM_BTNS-1:0] levelVec;
    logic [NUM_BTNS-1:0] pressVec;
    logic [NUM_BTNS-1:0] releaseVec;

    assign rawBtns = {bus.btnD, bus.btnL, bus.btnR, bus.btnU, bus.btnC};

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_deb
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .SYNC_STAGES    (SYNC_STAGES)
            ) uDebounce (
                .clk   (clk),
                .reset (reset),
                .btnRaw(rawBtns[gi]),
                .level (levelVec[gi]),
                .rise  (pressVec[gi]),
                .fall  (releaseVec[gi])
            );
        end
    endgenerate

    state_t stateReg, stateNext;
    dir_t   dirReg, dirNext;
    logic   centreReg, centreNext;
    dir_t   pressedDir;

    assign pressedDir = pickDir(pressVec);

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg  <= ST_IDLE;
            dirReg    <= DIR_NONE;
            centreReg <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            dirReg    <= dirNext;
            centreReg <= centreNext;
        end
    end

    always_comb begin
        stateNext  = stateReg;
        dirNext    = dirReg;
        centreNext = 1'b0;
        case (stateReg)
            ST_IDLE: begin
                if (pressVec[BTN_C]) begin
                    stateNext  = ST_STOPPED;
                    centreNext = 1'b1;
                end
            end
            ST_STOPPED: begin
                if (pressVec[BTN_C]) begin
                    centreNext = 1'b1;
                end else if (pressedDir != DIR_NONE) begin
                    stateNext = ST_MOVING;
                    dirNext   = pressedDir;
                end
            end
            ST_MOVING: begin
                // A fresh direction beats a coincident stop; downstream re-asserts stop if still blocked.
                if (pressedDir != DIR_NONE) begin
                    dirNext = pressedDir;
                end else if (bus.stop) begin
                    stateNext = ST_STOPPED;
                    dirNext   = DIR_NONE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
                dirNext   = DIR_NONE;
            end
        endcase
    end

    assign bus.btn_level   = levelVec;
    assign bus.btn_press   = pressVec;
    assign bus.btn_release = releaseVec;
    assign bus.armed       = (stateReg != ST_IDLE);
    assign bus.centre_req  = centreReg;
    assign bus.dir_cmd     = dirReg;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed plus randomized bench for btn_conditioner against a
// sample-window reference model of debouncing and the direction rules.
`timescale 1ns/1ps
module tb_btn_conditioner;
    import btn_pkg::*;

    localparam int DEB = 4;
    localparam int SYN = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] rawVec = '0;
    logic stopIn = 1'b0;

    always #5 clk = ~clk;

    btn_conditioner_if bus ();

    assign bus.btnC = rawVec[0];
    assign bus.btnU = rawVec[1];
    assign bus.btnR = rawVec[2];
    assign bus.btnL = rawVec[3];
    assign bus.btnD = rawVec[4];
    assign bus.stop = stopIn;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .SYNC_STAGES    (SYN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int compared = 0;
    int mismatched = 0;

    // Reference model: hist[0] is the raw vector seen at the latest edge.
    logic [4:0] hist[$];
    logic [4:0] mLevel = '0;
    logic [4:0] mPress = '0;
    logic [4:0] mRel = '0;
    logic       mArmed = 1'b0;
    logic       mCentre = 1'b0;
    logic [2:0] mDir = '0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelEdge();
        logic [4:0] prevPress;
        logic allDiffer;
        int first;
        prevPress = mPress;
        if (reset) begin
            hist.delete();
            for (int i = 0; i < SYN + DEB; i++) hist.push_back(5'b0);
            mLevel = '0; mPress = '0; mRel = '0;
            mArmed = 1'b0; mCentre = 1'b0; mDir = '0;
        end else begin
            // Direction rules act on last cycle's press pulses.
            mCentre = 1'b0;
            if (!mArmed) begin
                if (prevPress[0]) begin
                    mArmed = 1'b1;
                    mCentre = 1'b1;
                end
            end else if (mDir == 3'd0 && prevPress[0]) begin
                mCentre = 1'b1;
            end else begin
                first = 0;
                for (int b = 4; b >= 1; b--) if (prevPress[b]) first = b;
                if (first > 0) mDir = first[2:0];
                else if (stopIn) mDir = 3'd0;
            end
            // Level flips once the last DEB synchronised samples all disagree with it.
            hist.push_front(rawVec);
            mPress = '0;
            mRel = '0;
            for (int b = 0; b < 5; b++) begin
                allDiffer = 1'b1;
                for (int k = SYN; k < SYN + DEB; k++)
                    if (hist[k][b] == mLevel[b]) allDiffer = 1'b0;
                if (allDiffer) begin
                    mLevel[b] = ~mLevel[b];
                    if (mLevel[b]) mPress[b] = 1'b1;
                    else mRel[b] = 1'b1;
                end
            end
            while (hist.size() > SYN + DEB) void'(hist.pop_back());
        end
    endtask

    task automatic checkAll();
        check("btn_level", 8'(bus.btn_level), 8'(mLevel));
        check("btn_press", 8'(bus.btn_press), 8'(mPress));
        check("btn_release", 8'(bus.btn_release), 8'(mRel));
        check("armed", 8'(bus.armed), 8'(mArmed));
        check("centre_req", 8'(bus.centre_req), 8'(mCentre));
        check("dir_cmd", 8'(bus.dir_cmd), 8'(mDir));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            modelEdge();
            #1;
            checkAll();
        end
    endtask

    initial begin
        int cnt;
        logic [4:0] bouncePat;

        // Reset
        step(3);
        check("reset_level", 8'(bus.btn_level), 8'h00);
        check("reset_dir", 8'(bus.dir_cmd), 8'h00);
        check("reset_armed", 8'(bus.armed), 8'h00);
        reset = 1'b0;
        step(2);

        // U bounce while unarmed: one press, no direction
        bouncePat = 5'b01101; // 1,0,1,1,0 from LSB
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            rawVec[1] = bouncePat[i];
            step(1);
            if (bus.btn_press[1]) cnt++;
        end
        rawVec[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (bus.btn_press[1]) cnt++;
        end
        check("u_bounce_press_count", 8'(cnt), 8'd1);
        check("u_unarmed_dir", 8'(bus.dir_cmd), 8'h00);
        rawVec[1] = 1'b0;
        step(12);

        // C press latency: level/press at edge 6, centre_req/armed at edge 7
        rawVec[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if (i == 5) check("c_press_early", 8'(bus.btn_press[0]), 8'd0);
            if (i == 6) begin
                check("c_press_edge6", 8'(bus.btn_press[0]), 8'd1);
                check("c_level_edge6", 8'(bus.btn_level[0]), 8'd1);
            end
            if (i == 7) begin
                check("c_centre_edge7", 8'(bus.centre_req), 8'd1);
                check("c_armed_edge7", 8'(bus.armed), 8'd1);
            end
        end
        rawVec[0] = 1'b0;
        step(10);

        // MOVING RIGHT, then stop, then re-centre
        rawVec[2] = 1'b1;
        step(8);
        check("move_right", 8'(bus.dir_cmd), 8'd2);
        rawVec[2] = 1'b0;
        step(8);
        check("right_latched", 8'(bus.dir_cmd), 8'd2);
        stopIn = 1'b1;
        step(1);
        stopIn = 1'b0;
        check("stop_clears_dir", 8'(bus.dir_cmd), 8'd0);
        rawVec[0] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (bus.centre_req) cnt++;
        end
        check("recentre_count", 8'(cnt), 8'd1);
        rawVec[0] = 1'b0;
        step(8);

        // MOVING UP, then C and L together: left wins, no re-centre
        rawVec[1] = 1'b1;
        step(8);
        check("move_up", 8'(bus.dir_cmd), 8'd1);
        rawVec[1] = 1'b0;
        step(8);
        rawVec[0] = 1'b1;
        rawVec[3] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (bus.centre_req) cnt++;
        end
        check("cl_dir_left", 8'(bus.dir_cmd), 8'd3);
        check("cl_no_centre", 8'(cnt), 8'd0);
        rawVec[0] = 1'b0;
        rawVec[3] = 1'b0;
        step(8);

        // stop coincident with press[R] while LEFT: press wins
        rawVec[2] = 1'b1;
        for (int i = 0; i < 20 && !mPress[2]; i++) step(1);
        stopIn = 1'b1;
        step(1);
        stopIn = 1'b0;
        check("stop_vs_press_dir", 8'(bus.dir_cmd), 8'd2);
        rawVec[2] = 1'b0;
        step(8);

        // Reset mid-count discards partial debounce
        rawVec[4] = 1'b1;
        step(3);
        reset = 1'b1;
        step(2);
        check("midreset_armed", 8'(bus.armed), 8'd0);
        check("midreset_level", 8'(bus.btn_level), 8'd0);
        reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            check("d_after_reset_press", 8'(bus.btn_press[4]), (i == 6) ? 8'd1 : 8'd0);
        end
        rawVec = '0;
        step(10);

        // Randomized held/bouncing buttons with stop and occasional reset
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 5) == 0) rawVec[b] = ~rawVec[b];
            stopIn = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 199) == 0);
            step(1);
        end
        rawVec = '0;
        stopIn = 1'b0;
        reset = 1'b0;
        step(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
